// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch unit.
package fetch_pkg;
  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between memory and decoder.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: credit-limited sequential requests, in-order response buffering,
// redirect with flush/drain of stale responses, misaligned-target fault state.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_code,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);
  localparam int            CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  fetch_state_e    r_state;
  logic            r_started;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic            r_fault;

  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic            w_credit;
  logic            w_accept;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW-1:0]   w_drop_nxt;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;

  // Requests in flight plus buffered words never exceed the FIFO size.
  assign w_credit = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < CREDIT_LIMIT;

  // r_started holds requests off for the first cycle so none leave while in reset.
  assign imem_req_valid = r_started && (r_state == FETCH) && w_credit;
  assign imem_req_addr  = r_req_pc;

  assign w_accept = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding violates the protocol and is ignored.
  assign w_rsp    = imem_rsp_valid && (r_outstanding != '0);
  assign w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(w_rsp);
  assign w_drop_nxt = (w_rsp && r_drop_cnt != '0) ? r_drop_cnt - CNT_ONE : r_drop_cnt;

  assign w_push       = w_rsp && (r_state == FETCH) && !redirect_valid && (!w_fifo_full || w_pop);
  assign w_pop        = instr_valid && instr_ready;
  assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

  assign instr_valid = !w_fifo_empty;
  assign instr_code  = w_fifo_empty ? '0 : w_head.instr;
  assign instr_pc    = w_fifo_empty ? '0 : w_head.pc;
  assign fetch_fault = r_fault;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_started     <= 1'b0;
      r_req_pc      <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_fault       <= 1'b0;
    end else begin
      r_started     <= 1'b1;
      r_outstanding <= w_outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_drop_cnt <= w_outstanding_nxt;
        if (is_word_aligned(redirect_pc)) begin
          r_req_pc <= redirect_pc;
          r_rsp_pc <= redirect_pc;
          r_fault  <= 1'b0;
          r_state  <= (w_outstanding_nxt != '0) ? DRAIN : FETCH;
        end else begin
          r_fault  <= 1'b1;
          r_state  <= FAULT;
        end
      end else begin
        unique case (r_state)
          FETCH: begin
            if (w_accept) r_req_pc <= r_req_pc + PC_STEP;
            if (w_push)   r_rsp_pc <= r_rsp_pc + PC_STEP;
          end
          DRAIN: begin
            r_drop_cnt <= w_drop_nxt;
            if (w_drop_nxt == '0) r_state <= FETCH;
          end
          FAULT: begin
            r_drop_cnt <= w_drop_nxt;
          end
          default: r_state <= FETCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: behavioural memory with programmable latency,
// decoder-side monitor, and one task per scenario.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  // Second instance only exercises the address wrap from a high reset PC.
  logic        w2_req_valid;
  logic [31:0] w2_req_addr;
  logic        w2_instr_valid;
  logic [31:0] w2_instr_code;
  logic [31:0] w2_instr_pc;
  logic        w2_fault;
  logic        w2_req_ready;
  logic        w2_rsp_valid;
  logic [31:0] w2_rsp_data;
  logic        w2_redirect_valid;
  logic [31:0] w2_redirect_pc;
  logic        w2_instr_ready;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_code(instr_code),
    .instr_pc(instr_pc), .fetch_fault(fetch_fault)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w2_req_valid), .imem_req_addr(w2_req_addr), .imem_req_ready(w2_req_ready),
    .imem_rsp_valid(w2_rsp_valid), .imem_rsp_data(w2_rsp_data),
    .redirect_valid(w2_redirect_valid), .redirect_pc(w2_redirect_pc),
    .instr_valid(w2_instr_valid), .instr_ready(w2_instr_ready), .instr_code(w2_instr_code),
    .instr_pc(w2_instr_pc), .fetch_fault(w2_fault)
  );

  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] code; } pop_t;

  pend_t       pend_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] acc2_q[$];
  pop_t        pop_q[$];
  int unsigned cyc;
  bit          mem_ready;
  int unsigned mem_lat;
  int          checks;
  int          errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ NOP_INSTR;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: every input changes 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0].addr);
      pend_q.delete(0);
    end
    imem_req_ready = mem_ready;
    if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      acc_q.push_back(imem_req_addr);
    end
    if (w2_req_valid && w2_req_ready) acc2_q.push_back(w2_req_addr);
  end

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) pop_q.push_back('{pc: instr_pc, code: instr_code});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (3) step();
    pend_q.delete();
    acc_q.delete();
    acc2_q.delete();
    pop_q.delete();
    imem_rsp_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_instr(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    mem_ready = 1'b1; mem_lat = 1; instr_ready = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 00000000", imem_req_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr_code !== 32'h0) begin errors++; $display("FAIL reset_instr_code: got %h expected 00000000", instr_code); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 00000000", instr_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    checks++; if (w2_req_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_wrap_addr: got %h expected fffffff8", w2_req_addr); end
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1; mem_lat = 1; instr_ready = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_before_start: got %b expected 0", imem_req_valid); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * (k - 1))) begin
        errors++; $display("FAIL b2b_req k=%0d: got valid=%b addr=%h expected valid=1 addr=%h", k, imem_req_valid, imem_req_addr, 32'(4 * (k - 1)));
      end
      if (k < 3) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_latency k=%0d: got instr_valid=%b expected 0", k, instr_valid); end
      end else begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (k - 3)) || instr_code !== mem_word(32'(4 * (k - 3)))) begin
          errors++; $display("FAIL b2b_instr k=%0d: got valid=%b pc=%h code=%h expected valid=1 pc=%h code=%h", k, instr_valid, instr_pc, instr_code, 32'(4 * (k - 3)), mem_word(32'(4 * (k - 3))));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    mem_ready = 1'b1; mem_lat = 1; instr_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL bp_accept_count: got %0d expected 4", acc_q.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid_low: got %b expected 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=00000000", instr_valid, instr_pc); end
    step();
    instr_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (pop_q.size() < 16) begin errors++; $display("FAIL bp_resume_count: got %0d expected at least 16", pop_q.size()); end
    bad = 0;
    foreach (pop_q[i]) if (pop_q[i].pc !== 32'(4 * i) || pop_q[i].code !== mem_word(32'(4 * i))) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_resume_order: got %0d bad entries expected 0", bad); end
  endtask

  task automatic test_redirect_drain();
    bit seen;
    mem_ready = 1'b1; mem_lat = 3; instr_ready = 1'b1;
    do_reset();
    step();
    step();
    @(negedge clk);
    mem_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL drain_outstanding: got %0d accepted expected 2", acc_q.size()); end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL drain_quiet: got req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid); end
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_no_req: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL drain_refetch: got valid=%b addr=%h expected valid=1 addr=00000100", imem_req_valid, imem_req_addr); end
    wait_instr(12, seen);
    checks++; if (!seen || instr_pc !== 32'h100 || instr_code !== mem_word(32'h100)) begin
      errors++; $display("FAIL drain_first_instr: got seen=%b pc=%h code=%h expected pc=00000100 code=%h", seen, instr_pc, instr_code, mem_word(32'h100));
    end
  endtask

  task automatic test_fault();
    bit seen;
    mem_ready = 1'b1; mem_lat = 1; instr_ready = 1'b1;
    do_reset();
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL fault_hold k=%0d: got fault=%b req_valid=%b instr_valid=%b expected 1 0 0", k, fetch_fault, imem_req_valid, instr_valid);
      end
    end
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL fault_no_requests: got %0d accepted expected 4", acc_q.size()); end
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++; $display("FAIL fault_clear: got fault=%b valid=%b addr=%h expected 0 1 00000200", fetch_fault, imem_req_valid, imem_req_addr);
    end
    wait_instr(8, seen);
    checks++; if (!seen || instr_pc !== 32'h200 || instr_code !== mem_word(32'h200)) begin
      errors++; $display("FAIL fault_first_instr: got seen=%b pc=%h code=%h expected pc=00000200", seen, instr_pc, instr_code);
    end
  endtask

  task automatic test_coincident();
    bit seen;
    mem_ready = 1'b1; mem_lat = 1; instr_ready = 1'b1;
    do_reset();
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin errors++; $display("FAIL coinc_handshake: got valid=%b pc=%h expected valid=1 pc=00000004", instr_valid, instr_pc); end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL coinc_flushed: got instr_valid=%b expected 0", instr_valid); end
    checks++; if (pop_q.size() != 2 || pop_q[pop_q.size() - 1].pc !== 32'h4) begin errors++; $display("FAIL coinc_pops: got %0d pops expected 2 ending at pc 00000004", pop_q.size()); end
    wait_instr(10, seen);
    checks++; if (!seen || instr_pc !== 32'h300 || instr_code !== mem_word(32'h300)) begin
      errors++; $display("FAIL coinc_first_instr: got seen=%b pc=%h code=%h expected pc=00000300", seen, instr_pc, instr_code);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (8) @(negedge clk);
    checks++; if (acc2_q.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", acc2_q.size()); end
    else begin
      checks++; if (acc2_q[0] !== 32'hFFFF_FFF8 || acc2_q[1] !== 32'hFFFF_FFFC || acc2_q[2] !== 32'h0) begin
        errors++; $display("FAIL wrap_addrs: got %h %h %h expected fffffff8 fffffffc 00000000", acc2_q[0], acc2_q[1], acc2_q[2]);
      end
    end
    checks++; if (w2_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_credit_stop: got %b expected 0", w2_req_valid); end
  endtask

  task automatic test_mid_reset();
    mem_ready = 1'b1; mem_lat = 1; instr_ready = 1'b1;
    do_reset();
    repeat (6) @(negedge clk);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || instr_valid !== 1'b0 || instr_pc !== 32'h0 || instr_code !== 32'h0) begin
      errors++; $display("FAIL midreset_state: got req_valid=%b addr=%h instr_valid=%b pc=%h code=%h expected 0 0 0 0 0", imem_req_valid, imem_req_addr, instr_valid, instr_pc, instr_code);
    end
    step();
    pend_q.delete(); acc_q.delete(); pop_q.delete();
    imem_rsp_valid = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h0) begin errors++; $display("FAIL midreset_first_req: got %0d accepts expected first addr 00000000", acc_q.size()); end
    checks++; if (pop_q.size() == 0 || pop_q[0].pc !== 32'h0 || pop_q[0].code !== mem_word(32'h0)) begin errors++; $display("FAIL midreset_first_instr: got %0d pops expected first pc 00000000", pop_q.size()); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; mem_ready = 1'b0; mem_lat = 1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    w2_req_ready = 1'b1; w2_rsp_valid = 1'b0; w2_rsp_data = '0;
    w2_redirect_valid = 1'b0; w2_redirect_pc = '0; w2_instr_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_redirect_drain();
    test_fault();
    test_coincident();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
